// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_pkg
//  Description : Shared definitions for the memory controller. Holds bus
//                widths, the IO region limit, the MEM_LEN size encodings,
//                the controller state encoding and a helper that turns a
//                size code into a byte count.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

  localparam int ADDR_LEN = 32;
  localparam int DATA_LEN = 32;

  // Addresses at or above this value are memory-mapped IO (UART).
  localparam logic [ADDR_LEN-1:0] IO_LIM = 32'h0003_0000;

  // MEM_LEN encodings carried on lsb_len.
  localparam logic [1:0] MEM_LEN_BYTE = 2'b00;
  localparam logic [1:0] MEM_LEN_HALF = 2'b01;
  localparam logic [1:0] MEM_LEN_WORD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Byte count of an access: size code + 1 (1, 2 or 4 bytes).
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    return {1'b0, len} + 3'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl_if
//  Description : Bus bundle of the memory controller: LSB request/response,
//                instruction-fetch request/response and the byte-wide RAM
//                port.
//                slave  : controller view (requests in, responses/RAM out)
//                master : requester / RAM view
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_ctrl_if;
  import mem_ctrl_pkg::*;

  // load/store unit
  logic                lsb_req;
  logic                lsb_wr;
  logic [ADDR_LEN-1:0] lsb_addr;
  logic [1:0]          lsb_len;
  logic [DATA_LEN-1:0] lsb_wdata;
  logic                lsb_done;
  logic [DATA_LEN-1:0] lsb_rdata;
  // instruction fetch
  logic                if_req;
  logic [ADDR_LEN-1:0] if_pc;
  logic                if_done;
  logic [DATA_LEN-1:0] if_data;
  // RAM byte port
  logic [7:0]          mem_din;
  logic [7:0]          mem_dout;
  logic [ADDR_LEN-1:0] mem_a;
  logic                mem_wr;

  modport slave (
    input  lsb_req, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
    input  if_req, if_pc,
    input  mem_din,
    output lsb_done, lsb_rdata, if_done, if_data,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output lsb_req, lsb_wr, lsb_addr, lsb_len, lsb_wdata,
    output if_req, if_pc,
    output mem_din,
    input  lsb_done, lsb_rdata, if_done, if_data,
    input  mem_dout, mem_a, mem_wr
  );

endinterface
`default_nettype wire

// File: rtl/mem_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_ctrl
//  Description : Byte-serial memory controller. Serves LSB loads/stores of
//                1/2/4 bytes and (optionally) 4-byte instruction fetches over
//                a single-byte RAM port with read latency 1.
//  Ports       : clk            - clock
//                reset          - synchronous active-high reset
//                rdy            - global ready, low freezes every register
//                clear          - misprediction flush
//                io_buffer_full - UART buffer full, stalls IO stores
//                bus            - mem_ctrl_if.slave (LSB, fetch, RAM port)
//  Config      : MEM_CTRL_IFETCH_EN - compile in the fetch port and the
//                LSB-over-fetch arbitration; otherwise if_done/if_data are 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       rdy,
  input  logic       clear,
  input  logic       io_buffer_full,
  mem_ctrl_if.slave  bus
);

  state_t              r_state, w_state;
  logic [ADDR_LEN-1:0] r_addr, w_addr;
  logic [ADDR_LEN-1:0] r_mem_a, w_mem_a;
  logic [2:0]          r_nbytes, w_nbytes;
  logic [2:0]          r_k, w_k;          // index of the byte address on mem_a
  logic                r_is_wr, w_is_wr;
  logic                r_src_if, w_src_if;
  logic [DATA_LEN-1:0] r_wdata, w_wdata;
  logic [DATA_LEN-1:0] r_buf, w_buf;      // load data being assembled
  logic [DATA_LEN-1:0] r_lsb_rdata;
  logic [7:0]          r_mem_dout, w_mem_dout;

  logic                w_io_stall;
  logic                w_kill;
  logic                w_lsb_done;
  logic [1:0]          w_cap_idx;
  logic [1:0]          w_wr_idx;

  // Stall is evaluated in the cycle itself so mem_wr drops immediately.
  assign w_io_stall = (r_state == ST_WRITE) && (r_addr >= IO_LIM) && io_buffer_full;
  // A flushed load must not report completion; stores are already committed.
  assign w_kill     = (r_state == ST_DONE) && !r_is_wr && clear;
  assign w_lsb_done = (r_state == ST_DONE) && !r_src_if && !w_kill;
  // Byte arriving on mem_din belongs to the previous address (latency 1).
  assign w_cap_idx  = r_k[1:0] - 2'd1;
  assign w_wr_idx   = r_k[1:0] + 2'd1;

  assign bus.mem_a     = r_mem_a;
  assign bus.mem_dout  = r_mem_dout;
  assign bus.mem_wr    = (r_state == ST_WRITE) && !w_io_stall;
  assign bus.lsb_done  = w_lsb_done;
  // New data is shown during the done cycle and committed when it retires.
  assign bus.lsb_rdata = (w_lsb_done && !r_is_wr) ? r_buf : r_lsb_rdata;

`ifdef MEM_CTRL_IFETCH_EN
  logic [DATA_LEN-1:0] r_if_data;
  logic                w_if_done;

  assign w_if_done   = (r_state == ST_DONE) && r_src_if && !w_kill;
  assign bus.if_done = w_if_done;
  assign bus.if_data = w_if_done ? r_buf : r_if_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_if_data <= '0;
    end else if (rdy && w_if_done) begin
      r_if_data <= r_buf;
    end
  end
`else
  logic w_unused_if;
  assign w_unused_if = ^{bus.if_req, bus.if_pc};
  assign bus.if_done = 1'b0;
  assign bus.if_data = '0;
`endif

  always_comb begin
    w_state    = r_state;
    w_addr     = r_addr;
    w_mem_a    = r_mem_a;
    w_nbytes   = r_nbytes;
    w_k        = r_k;
    w_is_wr    = r_is_wr;
    w_src_if   = r_src_if;
    w_wdata    = r_wdata;
    w_buf      = r_buf;
    w_mem_dout = r_mem_dout;

    case (r_state)
      ST_IDLE: begin
        if (!clear && bus.lsb_req) begin
          w_state  = bus.lsb_wr ? ST_WRITE : ST_READ;
          w_addr   = bus.lsb_addr;
          w_mem_a  = bus.lsb_addr;
          w_nbytes = len_to_bytes(bus.lsb_len);
          w_k      = '0;
          w_is_wr  = bus.lsb_wr;
          w_src_if = 1'b0;
          w_wdata  = bus.lsb_wdata;
          w_buf    = '0;
          if (bus.lsb_wr) begin
            w_mem_dout = bus.lsb_wdata[7:0];
          end
        end
`ifdef MEM_CTRL_IFETCH_EN
        else if (!clear && bus.if_req) begin
          w_state  = ST_READ;
          w_addr   = bus.if_pc;
          w_mem_a  = bus.if_pc;
          w_nbytes = len_to_bytes(MEM_LEN_WORD);
          w_k      = '0;
          w_is_wr  = 1'b0;
          w_src_if = 1'b1;
          w_buf    = '0;
        end
`endif
      end

      ST_READ: begin
        if (clear) begin
          w_state = ST_IDLE;
          w_k     = '0;
        end else begin
          if (r_k != 3'd0) begin
            w_buf[{w_cap_idx, 3'b000} +: 8] = bus.mem_din;
          end
          // One extra cycle after the last address collects its byte.
          if (r_k == r_nbytes) begin
            w_state = ST_DONE;
          end else begin
            w_k = r_k + 3'd1;
            if (r_k + 3'd1 < r_nbytes) begin
              w_mem_a = r_mem_a + 32'd1;
            end
          end
        end
      end

      ST_WRITE: begin
        if (!w_io_stall) begin
          if (r_k + 3'd1 == r_nbytes) begin
            w_state = ST_DONE;
          end else begin
            w_k        = r_k + 3'd1;
            w_mem_a    = r_mem_a + 32'd1;
            w_mem_dout = r_wdata[{w_wr_idx, 3'b000} +: 8];
          end
        end
      end

      ST_DONE: begin
        w_state = ST_IDLE;
        w_k     = '0;
      end

      default: begin
        w_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_mem_a     <= '0;
      r_nbytes    <= '0;
      r_k         <= '0;
      r_is_wr     <= 1'b0;
      r_src_if    <= 1'b0;
      r_wdata     <= '0;
      r_buf       <= '0;
      r_mem_dout  <= '0;
      r_lsb_rdata <= '0;
    end else if (rdy) begin
      r_state    <= w_state;
      r_addr     <= w_addr;
      r_mem_a    <= w_mem_a;
      r_nbytes   <= w_nbytes;
      r_k        <= w_k;
      r_is_wr    <= w_is_wr;
      r_src_if   <= w_src_if;
      r_wdata    <= w_wdata;
      r_buf      <= w_buf;
      r_mem_dout <= w_mem_dout;
      if (w_lsb_done && !r_is_wr) begin
        r_lsb_rdata <= r_buf;
      end
    end
  end

endmodule
`default_nettype wire
